pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Generic, parametrised inter-stage pipeline buffer that supersedes fixed per-stage registers such as the EX/MEM latch.
- Replaces the global stall with a valid/ready handshake on both sides.
- Optional 2-entry skid mode removes the combinational ready path between stages.
- Adds a synchronous flush that inserts a bubble, plus saturating stall/bubble counters for performance analysis.

Parameters:
- DATA_W, WIDTH (all_pkgs, 32): width of the datapath payload (e.g. alu_result concatenated with reg_data2 uses 2*WIDTH).
- CTRL_W, $bits(stage_ctrl_t) (19): width of the control payload. A zero control word is a NOP.
- SKID, 1: 0 gives a single register with a combinational ready; 1 gives a 2-entry skid buffer with a registered ready.
- CLEAR_DATA_ON_FLUSH, 1: 1 zeroes the data payload on flush; 0 leaves the data payload as is (only valid and ctrl are cleared).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  buffer accepts a beat this cycle
- in_data  in  DATA_W  upstream data payload
- in_ctrl  in  CTRL_W  upstream control payload
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  data payload of the head entry
- out_ctrl  out  CTRL_W  control payload of the head entry; 0 when !out_valid
- occupancy  out  2  number of held entries (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready
- bubble_cnt  out  CNT_W  cycles with !out_valid && out_ready

Behaviour:
- Reset (rst_n=0, async assert, sync deassert by design convention):
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, both counters=0.
  - in_ready=1.
- Transfer rule: an input beat moves when in_valid && in_ready; an output beat moves when out_valid && out_ready. Order is strictly FIFO.
- Latency: an accepted beat appears on out_* on the next cycle. There is no combinational in-to-out path.
- Hold: while out_valid && !out_ready, out_data and out_ctrl are stable.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - occupancy is at most 1.
- SKID=1:
  - Entries are main (drives out_*) and skid.
  - in_ready = !skid_valid, driven from a flop.
  - Accept with main empty, or main draining this cycle: the beat goes to main.
  - Accept with main full and !out_ready: the beat goes to skid.
  - out_ready with skid full: main <= skid and skid is emptied.
  - Accept and drain in the same cycle with occupancy=1: main <= the new beat and occupancy stays 1.
  - Full (occupancy=2): in_ready=0 and upstream must hold its beat.
- Flush (priority below reset, above all else):
  - At the next edge, all entries are invalid, occupancy=0 and ctrl is zeroed in all entries.
  - Data is zeroed if CLEAR_DATA_ON_FLUSH=1.
  - An input beat handshaked in the flush cycle is dropped.
  - The output beat in the flush cycle still counts as delivered if out_ready=1.
  - in_ready=1 on the following cycle.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 (no wrap).
  - Cleared only by reset; flush does not affect them.
- Reset mid-operation: all held beats are lost immediately and outputs go to their reset values asynchronously.
- in_valid with X payload while in_valid=0 is ignored (payload is not captured).

Decomposition:
- all_pkgs gains:
  - stage_ctrl_t packed struct {rd[4:0], funct3[2:0], opcode[6:0], reg_wr_en, mem_to_reg, wb_sel[1:0]}, 19 bits.
  - constant NOP_CTRL = '0.
- Sub-module sat_counter (params W; ports clk, rst_n, inc, count) is instantiated twice.

Test Plan:
- Reset, then stream beats 0x11, 0x22, 0x33 with out_ready=1 -> outputs 0x11, 0x22, 0x33 one cycle after each accept; occupancy=1 throughout; stall_cnt=0.
- SKID=1: accept 0xA then 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data holds 0xA for 5 cycles, stall_cnt=5. Then out_ready=1 -> 0xA, 0xB delivered in order and in_ready=1 one cycle later.
- SKID=0 with the same stimulus -> 0xB is not accepted while out_valid && !out_ready; in_ready follows out_ready in the same cycle.
- Occupancy=2 plus flush=1 with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xC never appears; out_data=0 when CLEAR_DATA_ON_FLUSH=1.
- CNT_W=4, out_ready=1, idle for 20 cycles -> bubble_cnt saturates at 15 and stays at 15.
- Assert rst_n low mid-stream with occupancy=2 -> out_valid=0 and occupancy=0 asynchronously, before the next edge; counters=0.

Source files
------------

// File: rtl/all_pkgs.sv
// Shared pipeline types: datapath width and the per-stage control word.
package all_pkgs;

    localparam int unsigned WIDTH = 32;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] opcode;
        logic       reg_wr_en;
        logic       mem_to_reg;
        logic [1:0] wb_sel;
    } stage_ctrl_t;

    // An all-zero control word never writes state, so it doubles as a bubble.
    localparam stage_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline stall/bubble statistics.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with valid/ready on both sides, optional
// 2-entry skid mode, synchronous flush and stall/bubble statistics.
module pipe_stage_buf
    import all_pkgs::*;
#(
    parameter int unsigned DATA_W              = WIDTH,
    parameter int unsigned CTRL_W              = $bits(stage_ctrl_t),
    parameter bit          SKID                = 1'b1,
    parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W               = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              accept;
    logic              drain;

    assign accept = in_valid && in_ready;
    assign drain  = main_valid && out_ready;

    // Skid mode breaks the ready path: in_ready comes straight off a flop.
    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = !skid_valid;
        end else begin : g_comb_ready
            assign in_ready = !main_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            if (CLEAR_DATA_ON_FLUSH) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else if (!main_valid || drain) begin
            // Head slot frees up: refill from skid first to keep FIFO order.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept && SKID) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_ctrl  <= in_ctrl;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : CTRL_W'(NOP_CTRL);
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (main_valid && !out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!main_valid && out_ready),
        .count (bubble_cnt)
    );

endmodule
